// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the NoC output-port arbiter.
package noc_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Successor index in a ring of n ports.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Wrap-around priority search: first set request at or above rr_ptr, then from 0.
module noc_rr_pick #(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    int pos;
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves a value held and no latch is inferred.
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(rr_ptr) + k) % NUM_REQ;
      if (!valid && req[pos]) begin
        valid       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/noc_outport_arbiter.sv
// Packet-locking round-robin arbiter for one NoC router output port, with a
// forced release when the owning input goes quiet for too long.
module noc_outport_arbiter
  import noc_arb_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  LOCK_TIMEOUT = 255,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               reset_q_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] last_i,
  input  logic               stall_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               wrreq_o,
  output logic               locked_o,
  output logic               timeout_o
);

  localparam int              CNT_W      = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam bit              TIMEOUT_EN = (LOCK_TIMEOUT > 0);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, owner_q, gnt_idx_q, win_idx;
  logic [CNT_W-1:0]  idle_cnt_q;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid, owner_req, owner_last, win_last;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return IDX_W'(wrap_inc(int'(i), NUM_REQ));
  endfunction

  noc_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_i),
    .rr_ptr (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign owner_req  = req_i[owner_q];
  assign owner_last = last_i[owner_q];

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (reset_q_i) state_q <= ARB_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (wrreq_o && !win_last) state_d = ARB_LOCKED;
      ARB_LOCKED: if ((wrreq_o && owner_last) || timeout_o) state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  // A grant needs req_i[owner]=1 and the timeout needs it at 0, so a grant
  // always takes precedence over a coinciding timeout.
  always_comb begin
    gnt_o     = '0;
    timeout_o = 1'b0;
    win_idx   = owner_q;
    if (!reset_q_i) begin
      if (state_q == ARB_IDLE) begin
        win_idx = pick_idx;
        if (pick_valid && !stall_i) gnt_o = pick_onehot;
      end else if (owner_req && !stall_i) begin
        gnt_o[owner_q] = 1'b1;
      end else if (!owner_req && TIMEOUT_EN && idle_cnt_q == CNT_LAST) begin
        timeout_o = 1'b1;
      end
    end
  end

  assign wrreq_o   = |gnt_o;
  assign win_last  = last_i[win_idx];
  assign gnt_idx_o = wrreq_o ? win_idx : gnt_idx_q;
  assign locked_o  = (state_q == ARB_LOCKED);

  always_ff @(posedge clk_i) begin
    if (reset_q_i) begin
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      gnt_idx_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      if (wrreq_o) gnt_idx_q <= win_idx;
      if (state_q == ARB_IDLE) begin
        idle_cnt_q <= '0;
        if (wrreq_o) begin
          if (win_last) rr_ptr_q <= next_idx(win_idx);
          else          owner_q  <= win_idx;
        end
      end else if (wrreq_o) begin
        idle_cnt_q <= '0;
        if (owner_last) rr_ptr_q <= next_idx(owner_q);
      end else if (timeout_o) begin
        idle_cnt_q <= '0;
        rr_ptr_q   <= next_idx(owner_q);
      end else if (!owner_req && idle_cnt_q != '1) begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_outport_arbiter.sv
// Self-checking bench for noc_outport_arbiter: directed scenarios plus random
// traffic against a packet-level reference model.
module tb_noc_outport_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int IW = $clog2(N);

  logic          clk_i = 1'b0;
  logic          reset_q_i;
  logic [N-1:0]  req_i, last_i;
  logic          stall_i;
  logic [N-1:0]  gnt_o;
  logic [IW-1:0] gnt_idx_o;
  logic          wrreq_o, locked_o, timeout_o;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the output, where round-robin resumes, how long
  // the owner has been silent, and the last winner.
  bit m_locked;
  int m_owner, m_ptr, m_idle, m_idx;

  // Per-cycle observed and expected values.
  logic [N-1:0] obs_gnt, exp_gnt;
  logic         obs_wrreq, obs_locked, obs_timeout, exp_locked, exp_timeout;
  int           obs_idx, exp_idx;

  noc_outport_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(TO)) dut (
    .clk_i     (clk_i),
    .reset_q_i (reset_q_i),
    .req_i     (req_i),
    .last_i    (last_i),
    .stall_i   (stall_i),
    .gnt_o     (gnt_o),
    .gnt_idx_o (gnt_idx_o),
    .wrreq_o   (wrreq_o),
    .locked_o  (locked_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_idle = 0; m_idx = 0;
  endtask

  // Apply one cycle of inputs, capture outputs mid-cycle and advance the model.
  task automatic drive_cycle(input logic [N-1:0] req, input logic [N-1:0] last,
                             input logic stall, input logic rst);
    int  w;
    bit  found;
    reset_q_i = rst; req_i = req; last_i = last; stall_i = stall;
    @(negedge clk_i);
    obs_gnt = gnt_o; obs_wrreq = wrreq_o; obs_locked = locked_o;
    obs_timeout = timeout_o; obs_idx = int'(gnt_idx_o);

    w = -1; found = 1'b0; exp_timeout = 1'b0;
    if (!rst) begin
      if (!m_locked) begin
        if (!stall)
          for (int k = 0; k < N; k++)
            if (!found && req[(m_ptr + k) % N]) begin
              found = 1'b1; w = (m_ptr + k) % N;
            end
      end else if (req[m_owner] && !stall) begin
        w = m_owner;
      end else if (!req[m_owner] && m_idle == TO - 1) begin
        exp_timeout = 1'b1;
      end
    end
    exp_gnt = '0;
    if (w >= 0) exp_gnt[w] = 1'b1;
    exp_locked = m_locked;
    exp_idx    = (w >= 0) ? w : m_idx;

    if (rst) model_reset();
    else if (w >= 0) begin
      m_idx = w;
      if (!m_locked) begin
        if (last[w]) m_ptr = (w + 1) % N;
        else begin m_locked = 1'b1; m_owner = w; m_idle = 0; end
      end else begin
        m_idle = 0;
        if (last[w]) begin m_locked = 1'b0; m_ptr = (w + 1) % N; end
      end
    end else if (m_locked) begin
      if (exp_timeout) begin m_locked = 1'b0; m_ptr = (m_owner + 1) % N; m_idle = 0; end
      else if (!req[m_owner]) m_idle++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(4'b1111, 4'b1111, 1'b0, 1'b1);
    checks++; if (obs_gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", obs_gnt); end
    checks++; if (obs_wrreq !== 1'b0) begin errors++; $display("FAIL reset_wrreq: got %b want 0", obs_wrreq); end
    checks++; if (obs_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", obs_timeout); end
    drive_cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
    checks++; if (obs_locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", obs_locked); end
    checks++; if (obs_idx != 0) begin errors++; $display("FAIL reset_idx: got %0d want 0", obs_idx); end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(4'b1111, 4'b1111, 1'b0, 1'b0);
      checks++;
      if (obs_gnt !== (4'b0001 << order[i]))
        begin errors++; $display("FAIL rr_gnt[%0d]: got %b want port %0d", i, obs_gnt, order[i]); end
      checks++;
      if (obs_idx != order[i]) begin errors++; $display("FAIL rr_idx[%0d]: got %0d want %0d", i, obs_idx, order[i]); end
    end
  endtask

  task automatic test_packet_lock();
    int locked_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      drive_cycle((i < 3) ? 4'b0101 : 4'b0001, (i == 2) ? 4'b0101 : 4'b0001, 1'b0, 1'b0);
      locked_cycles += int'(obs_locked);
      checks++;
      if (obs_gnt !== ((i < 3) ? 4'b0100 : 4'b0001))
        begin errors++; $display("FAIL pkt_gnt[%0d]: got %b want %b", i, obs_gnt, (i < 3) ? 4'b0100 : 4'b0001); end
    end
    checks++;
    if (locked_cycles != 2) begin errors++; $display("FAIL pkt_locked_cycles: got %0d want 2", locked_cycles); end
  endtask

  task automatic test_stall();
    drive_cycle(4'b0010, 4'b0000, 1'b0, 1'b0);
    checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL stall_first: got %b want 0010", obs_gnt); end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(4'b1111, 4'b0000, 1'b1, 1'b0);
      checks++;
      if (obs_gnt !== 4'b0000 || obs_timeout !== 1'b0 || obs_locked !== 1'b1)
        begin errors++; $display("FAIL stall_hold[%0d]: gnt=%b to=%b lk=%b want 0000/0/1", i, obs_gnt, obs_timeout, obs_locked); end
    end
    drive_cycle(4'b1011, 4'b0010, 1'b0, 1'b0);
    checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL stall_resume: got %b want 0010", obs_gnt); end
    drive_cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
    checks++; if (obs_locked !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", obs_locked); end
  endtask

  task automatic test_timeout();
    drive_cycle(4'b0010, 4'b0000, 1'b0, 1'b0);
    checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL to_first: got %b want 0010", obs_gnt); end
    for (int c = 1; c <= 9; c++) begin
      drive_cycle(4'b0100, 4'b0100, 1'b0, 1'b0);
      checks++;
      if (obs_timeout !== (c == 8))
        begin errors++; $display("FAIL to_pulse[%0d]: got %b want %b", c, obs_timeout, (c == 8)); end
      checks++;
      if (obs_gnt !== ((c == 9) ? 4'b0100 : 4'b0000))
        begin errors++; $display("FAIL to_gnt[%0d]: got %b want %b", c, obs_gnt, (c == 9) ? 4'b0100 : 4'b0000); end
    end
  endtask

  task automatic test_reset_mid_packet();
    drive_cycle(4'b1000, 4'b0000, 1'b0, 1'b0);
    checks++; if (obs_gnt !== 4'b1000) begin errors++; $display("FAIL rstmid_lock: got %b want 1000", obs_gnt); end
    drive_cycle(4'b1010, 4'b0000, 1'b0, 1'b1);
    checks++; if (obs_gnt !== 4'b0000) begin errors++; $display("FAIL rstmid_gnt: got %b want 0000", obs_gnt); end
    drive_cycle(4'b1010, 4'b1010, 1'b0, 1'b0);
    checks++; if (obs_locked !== 1'b0) begin errors++; $display("FAIL rstmid_locked: got %b want 0", obs_locked); end
    checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL rstmid_next: got %b want 0010", obs_gnt); end
  endtask

  task automatic test_random();
    logic [N-1:0] req, last;
    logic         stall, rst;
    bit           sparse = 1'b0;
    int           timeouts = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc % 40 == 0) sparse = ($urandom_range(0, 1) == 1);
      for (int p = 0; p < N; p++) begin
        req[p]  = sparse ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
        last[p] = ($urandom_range(0, 2) == 0);
      end
      stall = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      drive_cycle(req, last, stall, rst);
      timeouts += int'(obs_timeout === 1'b1);
      checks++;
      if (obs_gnt !== exp_gnt || obs_wrreq !== (|exp_gnt))
        begin errors++; $display("FAIL rnd_gnt@%0d: got %b/%b want %b", cyc, obs_gnt, obs_wrreq, exp_gnt); end
      checks++;
      if (obs_idx != exp_idx) begin errors++; $display("FAIL rnd_idx@%0d: got %0d want %0d", cyc, obs_idx, exp_idx); end
      checks++;
      if (obs_locked !== exp_locked || obs_timeout !== exp_timeout)
        begin errors++; $display("FAIL rnd_state@%0d: lk=%b to=%b want %b/%b", cyc, obs_locked, obs_timeout, exp_locked, exp_timeout); end
      checks++;
      if (!$onehot0(obs_gnt) || (stall && obs_gnt !== 4'b0000))
        begin errors++; $display("FAIL rnd_onehot_stall@%0d: gnt=%b stall=%b", cyc, obs_gnt, stall); end
    end
    checks++;
    if (timeouts == 0) begin errors++; $display("FAIL rnd_timeout_seen: got 0 want >0"); end
  endtask

  initial begin
    reset_q_i = 1'b1; req_i = '0; last_i = '0; stall_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_stall();
    test_timeout();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noc_outport_arbiter.md
NOC_OUTPORT_ARBITER -- requirements
Module: noc_outport_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesting router input ports (legal range 2..16).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 255, giving the idle-owner cycles before forced release; 0 disables the timeout.
REQ-003 SHALL have localparam IDX_W = $clog2(NUM_REQ).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_q_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req_i, input, NUM_REQ bits: requester i has a flit at its FIFO head (inverted rx empty).
REQ-007 SHALL have port last_i, input, NUM_REQ bits: the head flit of requester i ends its packet; valid only while req_i[i] is high.
REQ-008 SHALL have port stall_i, input, 1 bit: the output link cannot accept a flit this cycle.
REQ-009 SHALL have port gnt_o, output, NUM_REQ bits: one-hot transfer strobe, driving the winner's rdreq.
REQ-010 SHALL have port gnt_idx_o, output, IDX_W bits: binary index of the current or most recent winner (output mux select).
REQ-011 SHALL have port wrreq_o, output, 1 bit: equals |gnt_o and drives the output link write.
REQ-012 SHALL have port locked_o, output, 1 bit: high while a packet owns the output.
REQ-013 SHALL have port timeout_o, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and LOCKED.
REQ-015 SHALL drive gnt_o combinationally from the registered state and the current inputs, giving 0-cycle latency from req to transfer.
REQ-016 SHALL never assert gnt_o when stall_i=1, and SHALL keep gnt_o at most one-hot.
REQ-017 In IDLE with any req_i set and stall_i=0, SHALL grant the first requester with req_i set, searching upward from rr_ptr with wrap-around (NUM_REQ-1 -> 0).
REQ-018 In IDLE, if the winner's last_i=1 (single-flit packet), SHALL stay in IDLE and set rr_ptr = winner+1 mod NUM_REQ.
REQ-019 In IDLE, if the winner's last_i=0, SHALL go to LOCKED with owner = winner.
REQ-020 In LOCKED, SHALL grant only the owner, and only when req_i[owner]=1 and stall_i=0; requests from other requesters SHALL be ignored.
REQ-021 In LOCKED, a granted flit with last_i[owner]=1 SHALL cause a return to IDLE and set rr_ptr = owner+1 mod NUM_REQ.
REQ-022 In LOCKED, SHALL keep idle_cnt, which:
  - increments on cycles with req_i[owner]=0;
  - holds on stall-only cycles;
  - clears on every grant.
REQ-023 When idle_cnt reaches LOCK_TIMEOUT-1 and req_i[owner] is still 0 (LOCK_TIMEOUT>0), SHALL:
  - pulse timeout_o for one cycle;
  - return to IDLE;
  - set rr_ptr = owner+1 mod NUM_REQ;
  - clear idle_cnt.
REQ-024 SHALL saturate idle_cnt, i.e. it never wraps.
REQ-025 Fairness: a continuously requesting port SHALL be granted within NUM_REQ-1 packet completions by other ports.
REQ-026 If a grant and the timeout condition coincide in the same cycle, the grant SHALL win and no timeout SHALL occur.
REQ-027 SHALL update gnt_idx_o to the winner on each grant and hold it otherwise.
REQ-028 SHALL drive locked_o = (state==LOCKED).

Reset
REQ-029 While reset_q_i=1, SHALL force gnt_o=0, wrreq_o=0 and timeout_o=0 combinationally.
REQ-030 On reset, SHALL set state=IDLE, rr_ptr=0, owner=0, gnt_idx_o=0 and idle_cnt=0.
REQ-031 Reset asserted mid-packet SHALL abandon the lock; the first grant after reset SHALL follow round-robin from index 0.

Structure
REQ-032 SHALL place the FSM state enum (ARB_IDLE, ARB_LOCKED) in shared package noc_arb_pkg.
REQ-033 SHALL implement the wrap-around priority search as sub-module noc_rr_pick:
  - inputs: req vector and rr_ptr;
  - outputs: one-hot vector, index and any-valid flag;
  - purely combinational.
REQ-034 One instance per router output port SHALL be sufficient; no internal storage of flits.

Verification
REQ-035 Bench SHALL cover: NUM_REQ=4, req=4'b1111 and last=4'b1111 constantly, stall=0 -> grant order 0,1,2,3,0 on consecutive cycles.
REQ-036 Bench SHALL cover: port 2 sends a 3-flit packet (last on 3rd flit) while port 0 requests throughout -> gnt_o = 0100 x3, then 0001; locked_o high for 2 cycles.
REQ-037 Bench SHALL cover: stall=1 for 5 cycles mid-packet -> gnt_o=0 and owner unchanged, idle_cnt unchanged, no timeout; transfer resumes on the first cycle stall=0.
REQ-038 Bench SHALL cover: LOCK_TIMEOUT=8, owner 1 drops req after its 1st flit -> timeout_o pulses exactly 8 cycles later, the next grant goes to port 2 if requesting.
REQ-039 Bench SHALL cover: reset_q_i=1 for one cycle while locked on port 3 -> locked_o=0 next cycle; with req=1010 the next grant goes to port 1.
REQ-040 Bench SHALL check the assertion that gnt_o is one-hot or zero and that gnt_o=0 whenever stall_i=1, over 10k random cycles.
